// File: rtl/player_countdown_timer_pkg.sv
// rtl/player_countdown_timer_pkg.sv - shared state encoding, BCD limits and time conversion helpers
package player_countdown_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAUSED  = 2'd1,
        ST_COUNT   = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

    localparam logic [3:0] BCD_MAX_UNITS    = 4'd9;
    localparam logic [3:0] BCD_MAX_SEC_TENS = 4'd5;
    localparam int         DEFAULT_INC_SEC  = 5;
    localparam int         DEFAULT_MAX_MIN  = 99;

    function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] lim);
        return (d > lim) ? lim : d;
    endfunction

    function automatic logic [13:0] bcd_to_seconds(input logic [7:0] mm, input logic [7:0] ss);
        logic [13:0] m;
        logic [13:0] s;
        m = 14'(mm[7:4]) * 14'd10 + 14'(mm[3:0]);
        s = 14'(ss[7:4]) * 14'd10 + 14'(ss[3:0]);
        return m * 14'd60 + s;
    endfunction

    function automatic logic [15:0] seconds_to_bcd(input logic [13:0] t);
        logic [13:0] m;
        logic [13:0] s;
        m = t / 14'd60;
        s = t % 14'd60;
        return {4'(m / 14'd10), 4'(m % 14'd10), 4'(s / 14'd10), 4'(s % 14'd10)};
    endfunction

endpackage

// File: rtl/player_countdown_timer_if.sv
// rtl/player_countdown_timer_if.sv - control and time-value bundle between chess-clock top and a player timer
interface player_countdown_timer_if;
    logic       i_ce;
    logic       i_load;
    logic [7:0] i_ld_min;
    logic [7:0] i_ld_sec;
    logic       i_run;
    logic       i_add_inc;
    logic [7:0] o_min_bcd;
    logic [7:0] o_sec_bcd;
    logic       o_running;
    logic       o_timeout;
    logic       o_sec_tick;

    modport master (
        output i_ce, i_load, i_ld_min, i_ld_sec, i_run, i_add_inc,
        input  o_min_bcd, o_sec_bcd, o_running, o_timeout, o_sec_tick
    );

    modport slave (
        input  i_ce, i_load, i_ld_min, i_ld_sec, i_run, i_add_inc,
        output o_min_bcd, o_sec_bcd, o_running, o_timeout, o_sec_tick
    );
endinterface

// File: rtl/player_countdown_timer_bcd_digit.sv
// rtl/player_countdown_timer_bcd_digit.sv - one BCD digit register with load and wrap-on-borrow decrement
module player_countdown_timer_bcd_digit #(
    parameter logic [3:0] LIMIT = 4'd9
) (
    input  logic       CLK,
    input  logic       CLR,
    input  logic       i_load,
    input  logic [3:0] i_load_val,
    input  logic       i_dec,
    output logic [3:0] o_q,
    output logic       o_zero
);
    logic [3:0] r_q;

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            r_q <= 4'd0;
        end else if (i_load) begin
            r_q <= i_load_val;
        end else if (i_dec) begin
            r_q <= (r_q == 4'd0) ? LIMIT : r_q - 4'd1;
        end
    end

    assign o_q    = r_q;
    assign o_zero = (r_q == 4'd0);
endmodule

// File: rtl/player_countdown_timer.sv
// rtl/player_countdown_timer.sv - per-player BCD MM:SS countdown with Fischer increment and sticky timeout
module player_countdown_timer
    import player_countdown_timer_pkg::*;
#(
    parameter int INC_SEC = DEFAULT_INC_SEC,
    parameter int MAX_MIN = DEFAULT_MAX_MIN
) (
    input logic                     CLK,
    input logic                     CLR,
    player_countdown_timer_if.slave bus
);
    localparam logic [13:0] CAP_SEC = 14'(MAX_MIN * 60 + 59);
    localparam logic [13:0] INC     = 14'(INC_SEC);

    state_t      r_state;
    logic        r_running;
    logic        r_timeout;
    logic [3:0]  w_su, w_st, w_mu, w_mt;
    logic        w_z_su, w_z_st, w_z_mu, w_z_mt;
    logic [7:0]  w_min, w_sec, w_ld_min, w_ld_sec;
    logic        w_tick, w_add, w_dec, w_ld_en, w_ld_zero, w_is_zero, w_at_one, w_expire, w_active;
    logic        w_dec_st, w_dec_mu, w_dec_mt;
    logic [13:0] w_sum, w_sat;
    logic [15:0] w_next_bcd;

    assign w_min = {w_mt, w_mu};
    assign w_sec = {w_st, w_su};

    assign w_ld_min = {clamp_digit(bus.i_ld_min[7:4], BCD_MAX_UNITS),
                       clamp_digit(bus.i_ld_min[3:0], BCD_MAX_UNITS)};
    assign w_ld_sec = {clamp_digit(bus.i_ld_sec[7:4], BCD_MAX_SEC_TENS),
                       clamp_digit(bus.i_ld_sec[3:0], BCD_MAX_UNITS)};

    assign w_active = (r_state == ST_PAUSED) || (r_state == ST_COUNT);
    assign w_tick   = bus.i_ce && (r_state == ST_COUNT);
    assign w_add    = bus.i_add_inc && w_active && !bus.i_load;
    assign w_dec    = w_tick && !bus.i_load && !w_add;
    assign w_ld_en  = bus.i_load || w_add;

    // A CE coinciding with ADD_INC is folded into the same write so that second is still charged.
    assign w_sum      = bcd_to_seconds(w_min, w_sec) + INC - {13'd0, w_tick};
    assign w_sat      = (w_sum > CAP_SEC) ? CAP_SEC : w_sum;
    assign w_next_bcd = bus.i_load ? {w_ld_min, w_ld_sec} : seconds_to_bcd(w_sat);

    assign w_dec_st = w_dec && w_z_su;
    assign w_dec_mu = w_dec_st && w_z_st;
    assign w_dec_mt = w_dec_mu && w_z_mu;

    assign w_ld_zero = ({w_ld_min, w_ld_sec} == 16'h0000);
    assign w_is_zero = w_z_su && w_z_st && w_z_mu && w_z_mt;
    assign w_at_one  = ({w_min, w_sec} == 16'h0001);
    assign w_expire  = (w_dec && w_at_one) || (w_add && w_tick && (w_sat == 14'd0));

    player_countdown_timer_bcd_digit #(.LIMIT(BCD_MAX_UNITS)) u_sec_units (
        .CLK(CLK), .CLR(CLR), .i_load(w_ld_en), .i_load_val(w_next_bcd[3:0]),
        .i_dec(w_dec), .o_q(w_su), .o_zero(w_z_su)
    );
    player_countdown_timer_bcd_digit #(.LIMIT(BCD_MAX_SEC_TENS)) u_sec_tens (
        .CLK(CLK), .CLR(CLR), .i_load(w_ld_en), .i_load_val(w_next_bcd[7:4]),
        .i_dec(w_dec_st), .o_q(w_st), .o_zero(w_z_st)
    );
    player_countdown_timer_bcd_digit #(.LIMIT(BCD_MAX_UNITS)) u_min_units (
        .CLK(CLK), .CLR(CLR), .i_load(w_ld_en), .i_load_val(w_next_bcd[11:8]),
        .i_dec(w_dec_mu), .o_q(w_mu), .o_zero(w_z_mu)
    );
    player_countdown_timer_bcd_digit #(.LIMIT(BCD_MAX_UNITS)) u_min_tens (
        .CLK(CLK), .CLR(CLR), .i_load(w_ld_en), .i_load_val(w_next_bcd[15:12]),
        .i_dec(w_dec_mt), .o_q(w_mt), .o_zero(w_z_mt)
    );

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            r_state   <= ST_IDLE;
            r_running <= 1'b0;
            r_timeout <= 1'b0;
        end else if (bus.i_load) begin
            r_state   <= w_ld_zero ? ST_IDLE : ST_PAUSED;
            r_running <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            case (r_state)
                ST_PAUSED: begin
                    if (bus.i_run && !w_is_zero) begin
                        r_state   <= ST_COUNT;
                        r_running <= 1'b1;
                    end
                end
                ST_COUNT: begin
                    if (w_expire) begin
                        r_state   <= ST_EXPIRED;
                        r_running <= 1'b0;
                        r_timeout <= 1'b1;
                    end else if (!bus.i_run) begin
                        r_state   <= ST_PAUSED;
                        r_running <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.o_min_bcd  = w_min;
    assign bus.o_sec_bcd  = w_sec;
    assign bus.o_running  = r_running;
    assign bus.o_timeout  = r_timeout;
    assign bus.o_sec_tick = w_tick;
endmodule
